ulpi_reg_arbiter: RTL and testbench

- Shares the single ULPI register-access path (TXCMD register read/write) between NUM_REQ requesters, e.g. PHY init sequencer and UART debug console.
- Sequences full ULPI immediate register write/read transactions and handles NXT, DIR turnaround and PHY aborts.
- Sits between requesters and the ULPI pad wrapper; bidirectional data is split into in/out/oe, with the tristate at top level.

---
 rtl/ulpi_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 32 +++
 rtl/ulpi_reg_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_ulpi_reg_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ulpi_pkg.sv
// Shared definitions for the ULPI register-access arbiter: TXCMD prefixes,
// FSM state encoding, common PHY register addresses and the TXCMD byte builder.
package ulpi_pkg;

  // TXCMD prefixes for immediate register access
  localparam logic [1:0] REG_WR = 2'b10;
  localparam logic [1:0] REG_RD = 2'b11;

  // Frequently used PHY register addresses
  localparam logic [5:0] VID_LO    = 6'h00;
  localparam logic [5:0] FUNC_CTRL = 6'h04;
  localparam logic [5:0] OTG_CTRL  = 6'h0A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TXCMD,
    S_WDATA,
    S_STOP,
    S_RD_TURN,
    S_RD_DATA,
    S_RD_END,
    S_DONE
  } state_t;

  // TXCMD byte for an immediate register write or read
  function automatic logic [7:0] txcmd_byte(input logic we, input logic [5:0] addr);
    return {(we ? REG_WR : REG_RD), addr};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker: scans the request vector starting at ptr and
// returns the first asserted requester as an index and a one-hot grant.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  grant
);

  // circular scan from ptr, first hit wins
  always_comb begin
    int k;
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    found = 1'b0;
    idx   = '0;
    grant = '0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!found && req[k]) begin
        found    = 1'b1;
        idx      = IW'(k);
        grant[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ulpi_reg_arbiter.sv
// Shares the ULPI immediate register-access path between NUM_REQ requesters.
// Sequences TXCMD/data/STP for writes and TXCMD/turnaround/data for reads,
// retries the command after a PHY abort (DIR rising), and arbitrates
// round-robin between requesters whenever the sequencer is idle.
// Optional macro ULPI_REG_TIMEOUT_EN adds a NXT/DIR wait timeout that
// finishes the transaction with err=1; without it the sequencer waits forever.
module ulpi_reg_arbiter
  import ulpi_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ulpi_dir,
  input  logic                 ulpi_nxt,
  output logic                 ulpi_stp,
  input  logic [7:0]           ulpi_data_in,
  output logic [7:0]           ulpi_data_out,
  output logic                 ulpi_data_oe,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_we,
  input  logic [6*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   ack,
  output logic [7:0]           rdata,
  output logic                 err,
  output logic                 busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               state, state_n;
  logic                 held;          // a grant is owned, from grant through DONE
  logic                 cur_we;
  logic [5:0]           cur_addr;
  logic [7:0]           cur_wdata;
  logic [NUM_REQ-1:0]   cur_grant;
  logic [IW-1:0]        cur_idx;
  logic [IW-1:0]        rr_ptr;
  logic [7:0]           rdata_q;

  logic                 arb_found;
  logic [IW-1:0]        arb_idx;
  logic [NUM_REQ-1:0]   arb_grant;
  logic                 start;
  logic                 to_hit;

  logic [7:0]           data_out_c;
  logic                 oe_c;
  logic                 stp_c;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .found (arb_found),
    .idx   (arb_idx),
    .grant (arb_grant)
  );

  // A fresh grant happens only from IDLE with no retry pending and the bus free
  assign start = (state == S_IDLE) && !held && arb_found && !ulpi_dir;

  // next-state and bus outputs decoded from the current state
  always_comb begin
    state_n    = state;
    data_out_c = '0;
    oe_c       = 1'b0;
    stp_c      = 1'b0;
    case (state)
      S_IDLE: begin
        // PHY owns the bus while DIR is high; a kept grant retries first
        if (!ulpi_dir && (held || arb_found)) state_n = S_TXCMD;
      end
      S_TXCMD: begin
        oe_c       = 1'b1;
        data_out_c = txcmd_byte(cur_we, cur_addr);
        if (ulpi_dir)      state_n = S_IDLE;
        else if (to_hit)   state_n = S_STOP;
        else if (ulpi_nxt) state_n = cur_we ? S_WDATA : S_RD_TURN;
      end
      S_WDATA: begin
        oe_c       = 1'b1;
        data_out_c = cur_wdata;
        if (ulpi_dir)                state_n = S_IDLE;
        else if (to_hit || ulpi_nxt) state_n = S_STOP;
      end
      S_STOP: begin
        oe_c    = 1'b1;
        stp_c   = 1'b1;
        state_n = S_DONE;
      end
      S_RD_TURN: begin
        // DIR together with NXT is an abort with RX: retry once DIR falls
        if (ulpi_dir && ulpi_nxt) state_n = S_IDLE;
        else if (ulpi_dir)        state_n = S_RD_DATA;
        else if (to_hit)          state_n = S_DONE;
      end
      S_RD_DATA: state_n = S_RD_END;
      S_RD_END: begin
        if (!ulpi_dir || to_hit) state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // state register, grant latch, read capture and round-robin pointer
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (reset) begin
      state     <= S_IDLE;
      held      <= 1'b0;
      cur_we    <= 1'b0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      cur_grant <= '0;
      cur_idx   <= '0;
      rr_ptr    <= '0;
      rdata_q   <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        held      <= 1'b1;
        cur_we    <= req_we[arb_idx];
        cur_addr  <= req_addr[6*arb_idx +: 6];
        cur_wdata <= req_wdata[8*arb_idx +: 8];
        cur_grant <= arb_grant;
        cur_idx   <= arb_idx;
      end
      if (state == S_RD_DATA) rdata_q <= ulpi_data_in;
      if (to_hit) rdata_q <= '0;
      if (state == S_DONE) begin
        held   <= 1'b0;
        rr_ptr <= (cur_idx == IW'(NUM_REQ - 1)) ? '0 : cur_idx + IW'(1);
      end
    end
  end

`ifdef ULPI_REG_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] to_cnt;
  logic          to_flag;
  logic          waiting;

  assign waiting = state inside {S_TXCMD, S_WDATA, S_RD_TURN, S_RD_END};
  assign to_hit  = waiting && (to_cnt == CW'(TIMEOUT_CYC - 1));

  // wait-cycle counter restarts on every state change; flag marks a timed-out transaction
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else begin
      if (!waiting || (state_n != state)) to_cnt <= '0;
      else                                to_cnt <= to_cnt + 1'b1;
      if (start)       to_flag <= 1'b0;
      else if (to_hit) to_flag <= 1'b1;
    end
  end

  assign err = (state == S_DONE) && to_flag;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC != 0);
  assign to_hit         = 1'b0;
  assign err            = 1'b0;
`endif

  // The link never drives while the PHY holds DIR high
  assign ulpi_data_oe  = oe_c & ~ulpi_dir;
  assign ulpi_data_out = data_out_c;
  assign ulpi_stp      = stp_c;
  assign ack           = (state == S_DONE) ? cur_grant : '0;
  assign rdata         = rdata_q;
  assign busy          = held | (start & ~reset);

endmodule

// File: tb/tb_ulpi_reg_arbiter.sv
// Self-checking bench for ulpi_reg_arbiter (NUM_REQ=2). A transaction-level
// model plays the PHY side and derives the expected bus waveform, ack, rdata
// and busy for every cycle; literal checks pin commands, latency and order.
module tb_ulpi_reg_arbiter;
  import ulpi_pkg::*;

  localparam int N = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           ulpi_dir, ulpi_nxt;
  logic [7:0]     ulpi_data_in;
  logic           ulpi_stp, ulpi_data_oe;
  logic [7:0]     ulpi_data_out;
  logic [N-1:0]   req, req_we, ack;
  logic [6*N-1:0] req_addr;
  logic [8*N-1:0] req_wdata;
  logic [7:0]     rdata;
  logic           err, busy;

  always #5 clk = ~clk;

  ulpi_reg_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(255)) dut (
    .clk           (clk),
    .reset         (reset),
    .ulpi_dir      (ulpi_dir),
    .ulpi_nxt      (ulpi_nxt),
    .ulpi_stp      (ulpi_stp),
    .ulpi_data_in  (ulpi_data_in),
    .ulpi_data_out (ulpi_data_out),
    .ulpi_data_oe  (ulpi_data_oe),
    .req           (req),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .ack           (ack),
    .rdata         (rdata),
    .err           (err),
    .busy          (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- model state ----------------
  logic       m_we[N];
  logic [5:0] m_addr[N];
  logic [7:0] m_wd[N];
  int         req_left[N];
  int         model_ptr = 0;
  int         grant_cyc = 0;

  // per-cycle expectations
  bit         exp_on = 1'b0;
  logic       exp_stp, exp_oe, exp_busy, exp_err;
  logic [7:0] exp_data, exp_rdata;
  bit         exp_dcare, exp_rchk;
  logic [N-1:0] exp_ack;

  // observations for literal checks
  int           last_ack_cyc = -1;
  logic [N-1:0] last_ack_vec = '0;
  logic [7:0]   last_ack_rdata = '0;

  // compare every cycle against the model, mid-cycle
  always @(negedge clk) begin
    if (exp_on) begin
      check($sformatf("c%0d stp", cyc), 32'(ulpi_stp), 32'(exp_stp));
      check($sformatf("c%0d oe", cyc), 32'(ulpi_data_oe), 32'(exp_oe));
      if (exp_dcare) check($sformatf("c%0d data_out", cyc), 32'(ulpi_data_out), 32'(exp_data));
      check($sformatf("c%0d ack", cyc), 32'(ack), 32'(exp_ack));
      check($sformatf("c%0d busy", cyc), 32'(busy), 32'(exp_busy));
      check($sformatf("c%0d err", cyc), 32'(err), 32'(exp_err));
      if (exp_rchk) check($sformatf("c%0d rdata", cyc), 32'(rdata), 32'(exp_rdata));
    end
    if (ack != '0) begin
      last_ack_cyc   = cyc;
      last_ack_vec   = ack;
      last_ack_rdata = rdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected end before %0d", cyc, 20000);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cyc_set(input logic d, input logic x, input logic [7:0] di);
    ulpi_dir     = d;
    ulpi_nxt     = x;
    ulpi_data_in = di;
  endtask

  task automatic expect_out(input logic s, input logic o, input logic [7:0] d, input bit dc,
                            input logic [N-1:0] a, input logic b);
    exp_stp   = s;
    exp_oe    = o;
    exp_data  = d;
    exp_dcare = dc;
    exp_ack   = a;
    exp_busy  = b;
    exp_err   = 1'b0;
    exp_rchk  = 1'b0;
  endtask

  task automatic drive_req();
    for (int i = 0; i < N; i++) begin
      req[i]               = (req_left[i] > 0);
      req_we[i]            = m_we[i];
      req_addr[6*i +: 6]   = m_addr[i];
      req_wdata[8*i +: 8]  = m_wd[i];
    end
  endtask

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] v;
    v    = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  // round-robin winner: first requester at or after the pointer
  function automatic int pick();
    int k;
    for (int i = 0; i < N; i++) begin
      k = (model_ptr + i) % N;
      if (req[k]) return k;
    end
    return -1;
  endfunction

  // One transaction from the grant cycle through DONE. nxt_wait: TXCMD cycles
  // without NXT; abort_at >= 0: DIR rises after that many TXCMD cycles and
  // stays high dir_hold cycles; rd_val: byte the PHY returns for a read.
  task automatic run_txn(input int nxt_wait, input int abort_at, input int dir_hold,
                         input logic [7:0] rd_val, output logic [7:0] cmd_seen);
    int w;
    logic [7:0] cmd;
    w = pick();
    if (w < 0) begin
      $display("FAIL run_txn: got no requester, expected one");
      $fatal(1);
    end
    cmd       = {m_we[w] ? REG_WR : REG_RD, m_addr[w]};
    grant_cyc = cyc;
    cyc_set(1'b0, 1'b0, 8'h00);
    expect_out(1'b0, 1'b0, 8'h00, 1'b1, '0, 1'b1);
    tick();
    if (abort_at >= 0) begin
      for (int c = 0; c < abort_at; c++) begin
        cyc_set(1'b0, 1'b0, 8'h00);
        expect_out(1'b0, 1'b1, cmd, 1'b1, '0, 1'b1);
        tick();
      end
      cyc_set(1'b1, 1'b0, 8'h00);
      expect_out(1'b0, 1'b0, cmd, 1'b0, '0, 1'b1);
      tick();
      for (int h = 1; h < dir_hold; h++) begin
        cyc_set(1'b1, 1'b0, 8'h00);
        expect_out(1'b0, 1'b0, 8'h00, 1'b1, '0, 1'b1);
        tick();
      end
      cyc_set(1'b0, 1'b0, 8'h00);
      expect_out(1'b0, 1'b0, 8'h00, 1'b1, '0, 1'b1);
      tick();
    end
    for (int c = 0; c < nxt_wait; c++) begin
      cyc_set(1'b0, 1'b0, 8'h00);
      expect_out(1'b0, 1'b1, cmd, 1'b1, '0, 1'b1);
      tick();
    end
    cyc_set(1'b0, 1'b1, 8'h00);
    expect_out(1'b0, 1'b1, cmd, 1'b1, '0, 1'b1);
    @(negedge clk);
    cmd_seen = ulpi_data_out;
    tick();
    if (m_we[w]) begin
      cyc_set(1'b0, 1'b1, 8'h00);
      expect_out(1'b0, 1'b1, m_wd[w], 1'b1, '0, 1'b1);
      tick();
      cyc_set(1'b0, 1'b0, 8'h00);
      expect_out(1'b1, 1'b1, 8'h00, 1'b1, '0, 1'b1);
      tick();
    end else begin
      cyc_set(1'b1, 1'b0, 8'h00);
      expect_out(1'b0, 1'b0, 8'h00, 1'b1, '0, 1'b1);
      tick();
      cyc_set(1'b1, 1'b0, rd_val);
      expect_out(1'b0, 1'b0, 8'h00, 1'b1, '0, 1'b1);
      tick();
      cyc_set(1'b0, 1'b0, 8'h00);
      expect_out(1'b0, 1'b0, 8'h00, 1'b1, '0, 1'b1);
      tick();
    end
    cyc_set(1'b0, 1'b0, 8'h00);
    expect_out(1'b0, 1'b0, 8'h00, 1'b1, onehot(w), 1'b1);
    exp_rchk  = !m_we[w];
    exp_rdata = rd_val;
    model_ptr = (w + 1) % N;
    req_left[w]--;
  endtask

  // cycle after DONE: requesters update, sequencer idle unless a new grant
  task automatic after_done();
    tick();
    drive_req();
    cyc_set(1'b0, 1'b0, 8'h00);
    expect_out(1'b0, 1'b0, 8'h00, 1'b1, '0, req != '0);
  endtask

  initial begin
    logic [7:0]   seen;
    logic [N-1:0] order [4];
    order = '{2'b01, 2'b10, 2'b01, 2'b10};

    reset = 1'b1;
    cyc_set(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < N; i++) begin
      m_we[i] = 1'b0; m_addr[i] = '0; m_wd[i] = '0; req_left[i] = 0;
    end
    drive_req();

    // reset state
    tick();
    expect_out(1'b0, 1'b0, 8'h00, 1'b1, '0, 1'b0);
    exp_rchk  = 1'b1;
    exp_rdata = 8'h00;
    exp_on    = 1'b1;
    tick();
    reset = 1'b0;
    expect_out(1'b0, 1'b0, 8'h00, 1'b1, '0, 1'b0);
    tick();

    // write OTG_CTRL=0x00 from req0, NXT on second TXCMD cycle
    m_we[0] = 1'b1; m_addr[0] = OTG_CTRL; m_wd[0] = 8'h00; req_left[0] = 1;
    tick();
    drive_req();
    run_txn(1, -1, 0, 8'h00, seen);
    check("wr_cmd", 32'(seen), 32'h8A);
    after_done();
    check("wr_latency", 32'(last_ack_cyc - grant_cyc), 32'd5);
    check("wr_ack", 32'(last_ack_vec), 32'b01);

    // read VID_LO from req1, PHY returns 0x24
    m_we[1] = 1'b0; m_addr[1] = VID_LO; m_wd[1] = 8'hEE; req_left[1] = 1;
    tick();
    drive_req();
    run_txn(0, -1, 0, 8'h24, seen);
    check("rd_cmd", 32'(seen), 32'hC0);
    after_done();
    check("rd_latency", 32'(last_ack_cyc - grant_cyc), 32'd5);
    check("rd_ack", 32'(last_ack_vec), 32'b10);
    check("rd_rdata", 32'(last_ack_rdata), 32'h24);

    // both requesters, two writes each: round-robin alternation
    m_we[0] = 1'b1; m_addr[0] = FUNC_CTRL; m_wd[0] = 8'h11; req_left[0] = 2;
    m_we[1] = 1'b1; m_addr[1] = OTG_CTRL;  m_wd[1] = 8'h22; req_left[1] = 2;
    tick();
    drive_req();
    for (int i = 0; i < 4; i++) begin
      run_txn(0, -1, 0, 8'h00, seen);
      after_done();
      check($sformatf("arb_order%0d", i), 32'(last_ack_vec), 32'(order[i]));
    end

    // DIR rises during TXCMD 0x84 before NXT: abort, then reissue
    m_we[0] = 1'b1; m_addr[0] = FUNC_CTRL; m_wd[0] = 8'h55; req_left[0] = 1;
    tick();
    drive_req();
    run_txn(0, 1, 3, 8'h00, seen);
    check("abort_retry_cmd", 32'(seen), 32'h84);
    after_done();
    check("abort_ack", 32'(last_ack_vec), 32'b01);
    check("abort_latency", 32'(last_ack_cyc - grant_cyc), 32'd9);

    // reset asserted in WDATA
    m_we[0] = 1'b1; m_addr[0] = OTG_CTRL; m_wd[0] = 8'hA5; req_left[0] = 1;
    tick();
    drive_req();
    cyc_set(1'b0, 1'b0, 8'h00);
    expect_out(1'b0, 1'b0, 8'h00, 1'b1, '0, 1'b1);
    tick();
    cyc_set(1'b0, 1'b1, 8'h00);
    expect_out(1'b0, 1'b1, 8'h8A, 1'b1, '0, 1'b1);
    tick();
    cyc_set(1'b0, 1'b0, 8'h00);
    reset = 1'b1;
    expect_out(1'b0, 1'b1, 8'hA5, 1'b1, '0, 1'b1);
    tick();
    expect_out(1'b0, 1'b0, 8'h00, 1'b1, '0, 1'b0);
    exp_rchk  = 1'b1;
    exp_rdata = 8'h00;
    tick();
    reset = 1'b0;
    req_left[0] = 0;
    drive_req();
    expect_out(1'b0, 1'b0, 8'h00, 1'b1, '0, 1'b0);
    model_ptr = 0;
    tick();

    // after reset the pointer starts at requester 0 again
    m_we[0] = 1'b1; m_addr[0] = OTG_CTRL; m_wd[0] = 8'h5A; req_left[0] = 1;
    m_we[1] = 1'b0; m_addr[1] = FUNC_CTRL; req_left[1] = 1;
    tick();
    drive_req();
    run_txn(0, -1, 0, 8'h00, seen);
    after_done();
    check("post_reset_first", 32'(last_ack_vec), 32'b01);
    run_txn(0, -1, 0, 8'h9C, seen);
    check("post_reset_rd_cmd", 32'(seen), 32'hC4);
    after_done();
    check("post_reset_second", 32'(last_ack_vec), 32'b10);
    check("post_reset_rdata", 32'(last_ack_rdata), 32'h9C);

`ifdef ULPI_REG_TIMEOUT_EN
    // NXT never comes: STP after 255 TXCMD cycles, then ack with err
    m_we[1] = 1'b1; m_addr[1] = OTG_CTRL; m_wd[1] = 8'h11; req_left[1] = 1;
    tick();
    drive_req();
    grant_cyc = cyc;
    cyc_set(1'b0, 1'b0, 8'h00);
    expect_out(1'b0, 1'b0, 8'h00, 1'b1, '0, 1'b1);
    for (int c = 0; c < 255; c++) begin
      tick();
      expect_out(1'b0, 1'b1, 8'h8A, 1'b1, '0, 1'b1);
    end
    tick();
    expect_out(1'b1, 1'b1, 8'h00, 1'b1, '0, 1'b1);
    tick();
    expect_out(1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 1'b1);
    exp_err   = 1'b1;
    exp_rchk  = 1'b1;
    exp_rdata = 8'h00;
    req_left[1] = 0;
    model_ptr   = 0;
    after_done();
    check("timeout_latency", 32'(last_ack_cyc - grant_cyc), 32'd257);
`endif

    tick();
    exp_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
